ee354_btn_debouncer: RTL and testbench

//   Debounces one mechanical push-button and generates clean, single-cycle clock enables from it.

---
 rtl/ee354_btn_debouncer.sv | 163 ++++++++++++++++
 tb/tb_ee354_btn_debouncer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_btn_debouncer.sv
// Push-button debouncer: 2-flop synchronizer plus FSM producing a debounced level and one-shot/repeat enables.
// Accepted press shows SCEN DEBOUNCE_CYC+2 edges after PB is first sampled high; no backpressure, outputs are Moore.
module ee354_btn_debouncer #(
    parameter int DEBOUNCE_CYC = 4194304,
    parameter int HOLD_CYC     = 67108864,
    parameter int REPEAT_CYC   = 16777216,
    parameter int CNT_W        = 27
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       PB,
    output logic       DPB,
    output logic       SCEN,
    output logic       MCEN,
    output logic       CCEN,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        INI       = 4'd0,
        WQ        = 4'd1,
        SCEN_ST   = 4'd2,
        WH        = 4'd3,
        MCEN_ST   = 4'd4,
        MCEN_CONT = 4'd5,
        CCR       = 4'd6,
        WFCR      = 4'd7
    } state_t;

    localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);

    logic             r_pb_meta;
    logic             r_pb_s;
    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_state_nxt;
    logic             w_cnt_inc;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_pb_meta <= 1'b0;
            r_pb_s    <= 1'b0;
        end else begin
            r_pb_meta <= PB;
            r_pb_s    <= r_pb_meta;
        end
    end

    // The counter only advances while the state holds, so any transition clears it.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= INI;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_inc ? (r_cnt + CNT_W'(1)) : '0;
        end
    end

    always_comb begin
        w_state_nxt = INI;
        w_cnt_inc   = 1'b0;
        case (r_state)
            INI: begin
                w_state_nxt = r_pb_s ? WQ : INI;
            end
            WQ: begin
                if (!r_pb_s) begin
                    w_state_nxt = INI;
                end else if (r_cnt == DB_TC) begin
                    w_state_nxt = SCEN_ST;
                end else begin
                    w_state_nxt = WQ;
                    w_cnt_inc   = 1'b1;
                end
            end
            SCEN_ST: begin
                w_state_nxt = WH;
            end
            WH: begin
                if (!r_pb_s) begin
                    w_state_nxt = CCR;
                end else if (r_cnt == HOLD_TC) begin
                    w_state_nxt = MCEN_ST;
                end else begin
                    w_state_nxt = WH;
                    w_cnt_inc   = 1'b1;
                end
            end
            MCEN_ST: begin
                w_state_nxt = MCEN_CONT;
            end
            MCEN_CONT: begin
                if (!r_pb_s) begin
                    w_state_nxt = CCR;
                end else if (r_cnt == REP_TC) begin
                    w_state_nxt = MCEN_ST;
                end else begin
                    w_state_nxt = MCEN_CONT;
                    w_cnt_inc   = 1'b1;
                end
            end
            CCR: begin
                w_state_nxt = WFCR;
            end
            WFCR: begin
                // A bounce back high restarts the release qualification via CCR.
                if (r_pb_s) begin
                    w_state_nxt = CCR;
                end else if (r_cnt == DB_TC) begin
                    w_state_nxt = INI;
                end else begin
                    w_state_nxt = WFCR;
                    w_cnt_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = INI;
            end
        endcase
    end

    always_comb begin
        DPB       = 1'b0;
        SCEN      = 1'b0;
        MCEN      = 1'b0;
        CCEN      = 1'b0;
        dbg_state = 4'd0;
        case (r_state)
            WQ: begin
                dbg_state = r_state;
            end
            SCEN_ST: begin
                DPB       = 1'b1;
                SCEN      = 1'b1;
                MCEN      = 1'b1;
                CCEN      = 1'b1;
                dbg_state = r_state;
            end
            WH, CCR, WFCR: begin
                DPB       = 1'b1;
                dbg_state = r_state;
            end
            MCEN_ST: begin
                DPB       = 1'b1;
                MCEN      = 1'b1;
                CCEN      = 1'b1;
                dbg_state = r_state;
            end
            MCEN_CONT: begin
                DPB       = 1'b1;
                CCEN      = 1'b1;
                dbg_state = r_state;
            end
            default: begin
                dbg_state = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ee354_btn_debouncer.sv
// Bench for ee354_btn_debouncer: age/run-length model checked every cycle plus directed literal checks.
module tb_ee354_btn_debouncer;

    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 3;

    logic       Clk;
    logic       reset;
    logic       PB;
    logic       DPB;
    logic       SCEN;
    logic       MCEN;
    logic       CCEN;
    logic [3:0] dbg_state;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int scen_cnt = 0;
    int t_scen = 0;
    int mcen_q[$];

    // Model: phase 0 idle (run of high samples), 1 held (age since acceptance), 2 releasing (age since last CCR)
    int   m_ph = 0;
    int   m_run = 0;
    int   m_age = 0;
    int   m_rel = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    ee354_btn_debouncer #(
        .DEBOUNCE_CYC(D),
        .HOLD_CYC    (H),
        .REPEAT_CYC  (R),
        .CNT_W       (4)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .PB       (PB),
        .DPB      (DPB),
        .SCEN     (SCEN),
        .MCEN     (MCEN),
        .CCEN     (CCEN),
        .dbg_state(dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_mcen_age(input int a);
        return (a >= H + 1) && (((a - (H + 1)) % (R + 1)) == 0);
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_run = 0; m_age = 0; m_rel = 0;
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            case (m_ph)
                0: begin
                    if (m_s2) begin
                        m_run = m_run + 1;
                        if (m_run == D + 1) begin
                            m_ph = 1; m_age = 0; m_run = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                1: begin
                    if (m_age >= 1 && !is_mcen_age(m_age) && !m_s2) begin
                        m_ph = 2; m_rel = 0;
                    end else begin
                        m_age = m_age + 1;
                    end
                end
                default: begin
                    if (m_rel == 0) m_rel = 1;
                    else if (m_s2) m_rel = 0;
                    else begin
                        m_rel = m_rel + 1;
                        if (m_rel == D + 1) begin
                            m_ph = 0; m_run = 0;
                        end
                    end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = PB;
        end
    end

    always @(negedge Clk) begin
        int e_dbg;
        int e_mc;
        e_mc = (m_ph == 1 && (m_age == 0 || is_mcen_age(m_age))) ? 1 : 0;
        if (m_ph == 0) e_dbg = (m_run > 0) ? 1 : 0;
        else if (m_ph == 1) begin
            if (m_age == 0) e_dbg = 2;
            else if (is_mcen_age(m_age)) e_dbg = 4;
            else if (m_age > H + 1) e_dbg = 5;
            else e_dbg = 3;
        end else e_dbg = (m_rel == 0) ? 6 : 7;
        chk("model_dpb", int'(DPB), (m_ph != 0) ? 1 : 0);
        chk("model_scen", int'(SCEN), (m_ph == 1 && m_age == 0) ? 1 : 0);
        chk("model_mcen", int'(MCEN), e_mc);
        chk("model_ccen", int'(CCEN), (m_ph == 1 && (m_age == 0 || m_age >= H + 1)) ? 1 : 0);
        chk("model_dbg", int'(dbg_state), e_dbg);
    end

    always @(negedge Clk) begin
        if (SCEN) begin
            scen_cnt++;
            t_scen = cyc;
        end
        if (MCEN && !SCEN) mcen_q.push_back(cyc - t_scen);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int got;
        reset = 1'b1;
        PB    = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_dpb", int'(DPB), 0);
        chk("rst_scen", int'(SCEN), 0);
        chk("rst_dbg", int'(dbg_state), 0);
        @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Clean press
        scen_cnt = 0;
        PB = 1'b1;
        repeat (2) @(negedge Clk);
        chk("t1_idle_before_sync", int'(dbg_state), 0);
        repeat (4) @(negedge Clk);
        chk("t1_scen_not_early", int'(SCEN), 0);
        chk("t1_state_wq", int'(dbg_state), 1);
        @(negedge Clk);
        chk("t1_scen", int'(SCEN), 1);
        chk("t1_mcen", int'(MCEN), 1);
        chk("t1_ccen", int'(CCEN), 1);
        chk("t1_dpb", int'(DPB), 1);
        chk("t1_state_scen", int'(dbg_state), 2);
        @(negedge Clk);
        chk("t1_scen_one_cycle", int'(SCEN), 0);
        chk("t1_state_wh", int'(dbg_state), 3);
        repeat (2) @(negedge Clk);
        PB = 1'b0;
        repeat (15) @(negedge Clk);
        chk("t1_dpb_released", int'(DPB), 0);
        chk("t1_scen_count", scen_cnt, 1);

        // Bounce on press
        scen_cnt = 0;
        PB = 1'b1; repeat (3) @(negedge Clk);
        PB = 1'b0; @(negedge Clk);
        PB = 1'b1; repeat (3) @(negedge Clk);
        PB = 1'b0; repeat (10) @(negedge Clk);
        chk("t2_no_scen", scen_cnt, 0);
        chk("t2_dpb", int'(DPB), 0);
        chk("t2_state", int'(dbg_state), 0);

        // Hold and auto-repeat
        scen_cnt = 0;
        mcen_q.delete();
        PB = 1'b1; repeat (40) @(negedge Clk);
        PB = 1'b0; repeat (15) @(negedge Clk);
        chk("t3_scen_count", scen_cnt, 1);
        chk("t3_nrep_ge4", (mcen_q.size() >= 4) ? 1 : 0, 1);
        got = (mcen_q.size() > 0) ? mcen_q[0] : -1; chk("t3_rep0", got, 9);
        got = (mcen_q.size() > 1) ? mcen_q[1] : -1; chk("t3_rep1", got, 13);
        got = (mcen_q.size() > 2) ? mcen_q[2] : -1; chk("t3_rep2", got, 17);
        got = (mcen_q.size() > 3) ? mcen_q[3] : -1; chk("t3_rep3", got, 21);

        // Release bounce
        scen_cnt = 0;
        PB = 1'b1; repeat (12) @(negedge Clk);
        PB = 1'b0; repeat (2) @(negedge Clk);
        PB = 1'b1; repeat (2) @(negedge Clk);
        PB = 1'b0;
        @(negedge Clk);
        chk("t4_ccr_reentry", int'(dbg_state), 6);
        repeat (4) @(negedge Clk);
        chk("t4_dpb_still_high", int'(DPB), 1);
        @(negedge Clk);
        chk("t4_dpb_low", int'(DPB), 0);
        chk("t4_state_ini", int'(dbg_state), 0);
        chk("t4_scen_count", scen_cnt, 1);
        repeat (4) @(negedge Clk);

        // Async reset mid auto-repeat
        PB = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge Clk);
            if (dbg_state == 4'd5) got = 1;
        end
        chk("t5_reach_mcen_cont", int'(dbg_state), 5);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_dpb", int'(DPB), 0);
        chk("t5_rst_ccen", int'(CCEN), 0);
        chk("t5_rst_mcen", int'(MCEN), 0);
        chk("t5_rst_dbg", int'(dbg_state), 0);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        repeat (6) @(negedge Clk);
        chk("t5_scen_not_early", int'(SCEN), 0);
        @(negedge Clk);
        chk("t5_scen_requalified", int'(SCEN), 1);
        PB = 1'b0;
        repeat (15) @(negedge Clk);

        // Illegal state recovery
        force dut.r_state = 4'hF;
        #1;
        chk("t6_ill_dpb", int'(DPB), 0);
        chk("t6_ill_scen", int'(SCEN), 0);
        chk("t6_ill_mcen", int'(MCEN), 0);
        chk("t6_ill_ccen", int'(CCEN), 0);
        chk("t6_ill_dbg", int'(dbg_state), 0);
        release dut.r_state;
        @(negedge Clk);
        chk("t6_state_recover", int'(dut.r_state), 0);
        chk("t6_dpb_after", int'(DPB), 0);
        repeat (3) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
